// File: rtl/alu_req_scheduler.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Captures the winning operands, holds them on alu_* while the ALU settles, then returns the result.
module alu_req_scheduler #(
    parameter int OP_W          = 3,
    parameter int SEL_W         = 2,
    parameter int RES_W         = 6,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [OP_W-1:0]  req0_a_i,
    input  logic [OP_W-1:0]  req0_b_i,
    input  logic [SEL_W-1:0] req0_sel_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [OP_W-1:0]  req1_a_i,
    input  logic [OP_W-1:0]  req1_b_i,
    input  logic [SEL_W-1:0] req1_sel_i,
    output logic [OP_W-1:0]  alu_a_o,
    output logic [OP_W-1:0]  alu_b_o,
    output logic [SEL_W-1:0] alu_sel_o,
    input  logic [RES_W-1:0] alu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [RES_W-1:0] rsp_result_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] op_count_o
);

    // state | meaning
    // IDLE  | waiting for a request; grant is combinational
    // ISSUE | operands held on alu_*, settle timer running
    // RESP  | rsp_valid high until the consumer takes it
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic [3:0] TMR_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [3:0]       tmr_q, tmr_d;
    logic [OP_W-1:0]  alu_a_q, alu_a_d;
    logic [OP_W-1:0]  alu_b_q, alu_b_d;
    logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
    logic             rsp_id_q, rsp_id_d;
    logic [RES_W-1:0] rsp_result_q, rsp_result_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic grant_id;
    logic grant_ok;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b0;
            tmr_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            tmr_q        <= tmr_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            op_count_q   <= op_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        tmr_d        = tmr_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        op_count_d   = op_count_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        grant_id     = (req0_valid_i && req1_valid_i) ? ptr_q : req1_valid_i;
        // Ready is gated by reset so nothing looks accepted while rst_n_i is low.
        grant_ok     = rst_n_i && (req0_valid_i || req1_valid_i);

        case (state_q)
            ST_IDLE: begin
                req0_ready_o = grant_ok && !grant_id;
                req1_ready_o = grant_ok && grant_id;
                if (grant_ok) begin
                    alu_a_d   = grant_id ? req1_a_i   : req0_a_i;
                    alu_b_d   = grant_id ? req1_b_i   : req0_b_i;
                    alu_sel_d = grant_id ? req1_sel_i : req0_sel_i;
                    rsp_id_d  = grant_id;
                    ptr_d     = !grant_id;
                    tmr_d     = TMR_LOAD;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tmr_q == 4'd0) begin
                    rsp_result_d = alu_result_i;
                    state_d      = ST_RESP;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    op_count_d = op_count_q + 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_sel_o    = alu_sel_q;
    assign rsp_valid_o  = (state_q == ST_RESP);
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign op_count_o   = op_count_q;

endmodule
